term_fb_ctrl: RTL and testbench
===============================

TERM_FB_CTRL -- requirements
Module: term_fb_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 80, meaning characters per row.
REQ-002 SHALL have parameter ROWS, default 30, meaning text rows.
REQ-003 SHALL have parameter BLINK_CYCLES, default 12500000, meaning clock cycles between cursor blink toggles.
REQ-004 SHALL have port clk_25mhz  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port resetn  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port in_valid  in  1  input byte present.
REQ-007 SHALL have port in_data  in  8  input byte.
REQ-008 SHALL have port in_ready  out  1  byte accepted on in_valid & in_ready.
REQ-009 SHALL have port fb_we  out  1  framebuffer write strobe, one cycle per write.
REQ-010 SHALL have port fb_addr  out  12  physical cell address, row*COLS + col, 0..COLS*ROWS-1.
REQ-011 SHALL have port fb_wdata  out  8  glyph code to write.
REQ-012 SHALL have port top_row  out  5  physical row shown at screen top; display reads from it.
REQ-013 SHALL have ports cursor_x  out  7 and cursor_y  out  5, logical cursor column and row.

Function
REQ-014 SHALL use states CLEAR_ALL, IDLE, WRITE, CLEAR_ROW; all outputs registered.
REQ-015 CLEAR_ALL SHALL write 0x20 to addresses 0..COLS*ROWS-1 ascending, one per cycle, then go to IDLE.
REQ-016 in_ready SHALL be 1 only in IDLE; an accepted byte SHALL move to WRITE, with fb_we asserted in the WRITE cycle.
REQ-017 Physical address SHALL be ((top_row + cursor_y) mod ROWS)*COLS + cursor_x, computed from the pre-update cursor.
REQ-018 A printable byte (0x20..0x7E) SHALL write in_data, then cursor_x+1; at cursor_x = COLS-1 it SHALL set cursor_x = 0 and perform line feed.
REQ-019 Byte 0x0D (CR) SHALL write 0x20 at the cursor cell, then set cursor_x = 0.
REQ-020 Byte 0x0A (LF) SHALL write 0x20 at the cursor cell, then perform line feed; cursor_x unchanged.
REQ-021 Byte 0x08 (BS) SHALL write 0x20 at the cursor cell, then decrement cursor_x, saturating at 0.
REQ-022 Other bytes SHALL be accepted and dropped: no write, no cursor change.
REQ-023 Line feed with cursor_y < ROWS-1 SHALL increment cursor_y and return to IDLE.
REQ-024 Line feed with cursor_y = ROWS-1 SHALL set top_row = (top_row+1) mod ROWS, keep cursor_y, then enter CLEAR_ROW.
REQ-025 CLEAR_ROW SHALL write 0x20 to the COLS cells of physical row old top_row, ascending, then go to IDLE; in_ready SHALL stay 0 throughout.
REQ-026 Blink counter SHALL count 0..BLINK_CYCLES-1 and set blink_pending on wrap; it runs in every state.
REQ-027 In IDLE with blink_pending and no in_valid, SHALL toggle cursor_on, write 0x5F (cursor_on now 1) or 0x20 (now 0) at the cursor cell, clear blink_pending, and keep in_ready 0 that cycle.
REQ-028 Priority SHALL be CLEAR_ALL > CLEAR_ROW > input byte > blink; a blink deferred by input SHALL stay pending, never lost and never counted twice.
REQ-029 Any accepted byte that writes SHALL clear cursor_on.
REQ-030 Simultaneous blink wrap and pending blink SHALL leave a single pending blink.
REQ-031 top_row and cursor_y arithmetic SHALL wrap mod ROWS; no fb_addr SHALL exceed COLS*ROWS-1.

Reset
REQ-032 With resetn = 0 at a clock edge, SHALL set state CLEAR_ALL, clear address counter, cursor_x = 0, cursor_y = 0, top_row = 0, cursor_on = 0, blink_pending = 0, blink counter 0, fb_we = 0, in_ready = 0, fb_addr = 0, fb_wdata = 0.
REQ-033 Reset asserted mid-operation (any state) SHALL abandon it; the next active cycle SHALL restart CLEAR_ALL at address 0.

Structure
REQ-034 Shared package term_pkg SHALL hold COLS/ROWS defaults, the control codes 0x08/0x0A/0x0D, glyph codes 0x20/0x5F, and the state enum.
REQ-035 The blink counter SHALL be the sub-module blink_timer (tick output, one cycle per wrap).

Verification
REQ-036 Release reset -> exactly 2400 fb_we pulses with 0x20, addresses 0..2399, then in_ready = 1.
REQ-037 Send 0x41 at cursor (0,0) -> next cycle fb_we, fb_addr 0, fb_wdata 0x41; cursor_x = 1.
REQ-038 Send 80 0x41 bytes from (0,0) -> last write at addr 79; cursor (0,1).
REQ-039 Cursor (5,29), top_row 0, send 0x0A -> write 0x20 at 2325; top_row = 1; 80 writes of 0x20 to addr 0..79; cursor (5,29); next byte 0x42 writes at addr 5.
REQ-040 BLINK_CYCLES = 4, keep in_valid high for 10 cycles -> no blink write; after in_valid drops -> one 0x5F write at the cursor cell.
REQ-041 Assert resetn = 0 during CLEAR_ROW -> after release, CLEAR_ALL restarts at 0, top_row = 0.

Source files
------------

// File: rtl/term_pkg.sv
// Shared constants, glyph/control codes and FSM state type for the
// text-terminal framebuffer controller.
package term_pkg;

    localparam int COLS_DEF = 80;
    localparam int ROWS_DEF = 30;

    localparam logic [7:0] CH_BS        = 8'h08;
    localparam logic [7:0] CH_LF        = 8'h0A;
    localparam logic [7:0] CH_CR        = 8'h0D;
    localparam logic [7:0] GLYPH_SPACE  = 8'h20;
    localparam logic [7:0] GLYPH_CURSOR = 8'h5F;
    localparam logic [7:0] PRINT_LO     = 8'h20;
    localparam logic [7:0] PRINT_HI     = 8'h7E;

    typedef enum logic [1:0] {
        CLEAR_ALL = 2'd0,
        IDLE      = 2'd1,
        WRITE     = 2'd2,
        CLEAR_ROW = 2'd3
    } state_e;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= PRINT_LO) && (b <= PRINT_HI);
    endfunction

endpackage

// File: rtl/term_fb_ctrl_if.sv
// Byte input handshake plus framebuffer write port of the terminal controller.
interface term_fb_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        fb_we;
    logic [11:0] fb_addr;
    logic [7:0]  fb_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, fb_we, fb_addr, fb_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, fb_we, fb_addr, fb_wdata
    );
endinterface

// File: rtl/term_fb_ctrl_blink.sv
// Free-running cursor blink timer: one-cycle tick each time the count wraps.
module blink_timer #(
    parameter int BLINK_CYCLES = 12500000
) (
    input  logic clk_25mhz,
    input  logic resetn,
    output logic tick
);
    localparam int         W    = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(BLINK_CYCLES - 1);

    logic [W-1:0] cnt_r;
    logic         tick_r;

    // counter 0..BLINK_CYCLES-1 with registered wrap pulse
    always_ff @(posedge clk_25mhz) begin
        if (!resetn) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (cnt_r == LAST) begin
            cnt_r  <= '0;
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + {{(W-1){1'b0}}, 1'b1};
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;
endmodule

// File: rtl/term_fb_ctrl.sv
// Text terminal controller: turns a byte stream into framebuffer cell writes,
// with hardware scrolling via top_row and a blinking underscore cursor.
module term_fb_ctrl
    import term_pkg::*;
#(
    parameter int COLS         = COLS_DEF,
    parameter int ROWS         = ROWS_DEF,
    parameter int BLINK_CYCLES = 12500000
) (
    input  logic       clk_25mhz,
    input  logic       resetn,
    term_fb_if.slave   bus,
    output logic [4:0] top_row,
    output logic [6:0] cursor_x,
    output logic [4:0] cursor_y
);
    localparam logic [11:0] LAST_CELL = 12'(COLS * ROWS - 1);
    localparam logic [11:0] LAST_COL  = 12'(COLS - 1);
    localparam logic [6:0]  LAST_X    = 7'(COLS - 1);
    localparam logic [4:0]  LAST_Y    = 5'(ROWS - 1);

    state_e      state_r, state_nxt;
    logic [11:0] addr_cnt_r, addr_cnt_nxt;
    logic [6:0]  cursor_x_r, cursor_x_nxt;
    logic [4:0]  cursor_y_r, cursor_y_nxt;
    logic [4:0]  top_row_r, top_row_nxt;
    logic        cursor_on_r, cursor_on_nxt;
    logic        blink_pending_r, blink_pending_nxt;
    logic        scroll_r, scroll_nxt;
    logic [11:0] clr_base_r, clr_base_nxt;
    logic        fb_we_r, fb_we_nxt;
    logic [11:0] fb_addr_r, fb_addr_nxt;
    logic [7:0]  fb_wdata_r, fb_wdata_nxt;
    logic        in_ready_r, in_ready_nxt;

    logic        tick_s;
    logic        accept_s;
    logic        blink_take_s;
    logic [5:0]  phys_sum_s;
    logic [4:0]  phys_row_s;
    logic [11:0] cur_addr_s;
    logic [11:0] row_base_s;
    logic [4:0]  top_wrap_s;
    logic        dec_write_s;
    logic        dec_lf_s;
    logic [7:0]  dec_glyph_s;
    logic [6:0]  dec_x_s;

    blink_timer #(.BLINK_CYCLES(BLINK_CYCLES)) u_blink (
        .clk_25mhz (clk_25mhz),
        .resetn    (resetn),
        .tick      (tick_s)
    );

    assign accept_s     = (state_r == IDLE) && in_ready_r && bus.in_valid;
    assign blink_take_s = (state_r == IDLE) && blink_pending_r && !bus.in_valid;

    // logical cursor row -> physical cell address, all mod ROWS
    always_comb begin
        phys_sum_s = {1'b0, top_row_r} + {1'b0, cursor_y_r};
        if (phys_sum_s >= 6'(ROWS)) begin
            phys_row_s = 5'(phys_sum_s - 6'(ROWS));
        end else begin
            phys_row_s = phys_sum_s[4:0];
        end
        if (top_row_r == LAST_Y) begin
            top_wrap_s = 5'd0;
        end else begin
            top_wrap_s = top_row_r + 5'd1;
        end
        cur_addr_s = 12'(phys_row_s) * 12'(COLS) + {5'd0, cursor_x_r};
        row_base_s = 12'(top_row_r) * 12'(COLS);
    end

    // decode the incoming byte into write / glyph / new column / line-feed
    always_comb begin
        dec_write_s = 1'b1;
        dec_lf_s    = 1'b0;
        dec_glyph_s = GLYPH_SPACE;
        dec_x_s     = cursor_x_r;
        if (is_printable(bus.in_data)) begin
            dec_glyph_s = bus.in_data;
            if (cursor_x_r == LAST_X) begin
                dec_x_s  = 7'd0;
                dec_lf_s = 1'b1;
            end else begin
                dec_x_s = cursor_x_r + 7'd1;
            end
        end else begin
            case (bus.in_data)
                CH_CR:   dec_x_s  = 7'd0;
                CH_LF:   dec_lf_s = 1'b1;
                CH_BS: begin
                    if (cursor_x_r == 7'd0) begin
                        dec_x_s = 7'd0;
                    end else begin
                        dec_x_s = cursor_x_r - 7'd1;
                    end
                end
                default: dec_write_s = 1'b0;
            endcase
        end
    end

    // next-state and next-output logic
    always_comb begin
        state_nxt     = state_r;
        addr_cnt_nxt  = addr_cnt_r;
        cursor_x_nxt  = cursor_x_r;
        cursor_y_nxt  = cursor_y_r;
        top_row_nxt   = top_row_r;
        cursor_on_nxt = cursor_on_r;
        scroll_nxt    = scroll_r;
        clr_base_nxt  = clr_base_r;
        fb_we_nxt     = 1'b0;
        fb_addr_nxt   = fb_addr_r;
        fb_wdata_nxt  = fb_wdata_r;
        in_ready_nxt  = 1'b0;
        // a fresh wrap always leaves exactly one pending blink
        blink_pending_nxt = tick_s | (blink_pending_r & ~blink_take_s);

        case (state_r)
            CLEAR_ALL: begin
                fb_we_nxt    = 1'b1;
                fb_addr_nxt  = addr_cnt_r;
                fb_wdata_nxt = GLYPH_SPACE;
                if (addr_cnt_r == LAST_CELL) begin
                    state_nxt    = IDLE;
                    addr_cnt_nxt = 12'd0;
                    in_ready_nxt = 1'b1;
                end else begin
                    addr_cnt_nxt = addr_cnt_r + 12'd1;
                end
            end
            IDLE: begin
                if (accept_s) begin
                    state_nxt    = WRITE;
                    cursor_x_nxt = dec_x_s;
                    scroll_nxt   = 1'b0;
                    if (dec_write_s) begin
                        fb_we_nxt     = 1'b1;
                        fb_addr_nxt   = cur_addr_s;
                        fb_wdata_nxt  = dec_glyph_s;
                        cursor_on_nxt = 1'b0;
                    end else begin
                        fb_we_nxt = 1'b0;
                    end
                    if (dec_lf_s && (cursor_y_r == LAST_Y)) begin
                        top_row_nxt  = top_wrap_s;
                        scroll_nxt   = 1'b1;
                        clr_base_nxt = row_base_s;
                    end else if (dec_lf_s) begin
                        cursor_y_nxt = cursor_y_r + 5'd1;
                    end else begin
                        cursor_y_nxt = cursor_y_r;
                    end
                end else if (blink_take_s) begin
                    cursor_on_nxt = ~cursor_on_r;
                    fb_we_nxt     = 1'b1;
                    fb_addr_nxt   = cur_addr_s;
                    fb_wdata_nxt  = cursor_on_r ? GLYPH_SPACE : GLYPH_CURSOR;
                    in_ready_nxt  = 1'b0;
                end else begin
                    in_ready_nxt = 1'b1;
                end
            end
            WRITE: begin
                if (scroll_r) begin
                    state_nxt    = CLEAR_ROW;
                    addr_cnt_nxt = 12'd0;
                end else begin
                    state_nxt    = IDLE;
                    in_ready_nxt = 1'b1;
                end
            end
            CLEAR_ROW: begin
                fb_we_nxt    = 1'b1;
                fb_addr_nxt  = clr_base_r + addr_cnt_r;
                fb_wdata_nxt = GLYPH_SPACE;
                if (addr_cnt_r == LAST_COL) begin
                    state_nxt    = IDLE;
                    addr_cnt_nxt = 12'd0;
                    scroll_nxt   = 1'b0;
                    in_ready_nxt = 1'b1;
                end else begin
                    addr_cnt_nxt = addr_cnt_r + 12'd1;
                end
            end
            default: begin
                state_nxt    = CLEAR_ALL;
                addr_cnt_nxt = 12'd0;
            end
        endcase
    end

    // state and output registers, synchronous active-low reset
    always_ff @(posedge clk_25mhz) begin
        if (!resetn) begin
            state_r         <= CLEAR_ALL;
            addr_cnt_r      <= 12'd0;
            cursor_x_r      <= 7'd0;
            cursor_y_r      <= 5'd0;
            top_row_r       <= 5'd0;
            cursor_on_r     <= 1'b0;
            blink_pending_r <= 1'b0;
            scroll_r        <= 1'b0;
            clr_base_r      <= 12'd0;
            fb_we_r         <= 1'b0;
            fb_addr_r       <= 12'd0;
            fb_wdata_r      <= 8'd0;
            in_ready_r      <= 1'b0;
        end else begin
            state_r         <= state_nxt;
            addr_cnt_r      <= addr_cnt_nxt;
            cursor_x_r      <= cursor_x_nxt;
            cursor_y_r      <= cursor_y_nxt;
            top_row_r       <= top_row_nxt;
            cursor_on_r     <= cursor_on_nxt;
            blink_pending_r <= blink_pending_nxt;
            scroll_r        <= scroll_nxt;
            clr_base_r      <= clr_base_nxt;
            fb_we_r         <= fb_we_nxt;
            fb_addr_r       <= fb_addr_nxt;
            fb_wdata_r      <= fb_wdata_nxt;
            in_ready_r      <= in_ready_nxt;
        end
    end

    assign bus.in_ready = in_ready_r;
    assign bus.fb_we    = fb_we_r;
    assign bus.fb_addr  = fb_addr_r;
    assign bus.fb_wdata = fb_wdata_r;
    assign top_row      = top_row_r;
    assign cursor_x     = cursor_x_r;
    assign cursor_y     = cursor_y_r;
endmodule

// File: tb/tb_term_fb_ctrl.sv
// Scoreboard bench: expected framebuffer writes are queued from a reference
// model when stimulus is driven and popped as the DUT issues fb_we.
module tb_term_fb_ctrl;
    logic clk_25mhz = 1'b0;
    logic resetn    = 1'b0;
    logic resetn_b  = 1'b0;

    always #20 clk_25mhz = ~clk_25mhz;

    term_fb_if fif ();
    term_fb_if bif ();

    logic [4:0] top_row, top_row_b;
    logic [6:0] cursor_x, cursor_x_b;
    logic [4:0] cursor_y, cursor_y_b;

    term_fb_ctrl dut (
        .clk_25mhz (clk_25mhz),
        .resetn    (resetn),
        .bus       (fif.slave),
        .top_row   (top_row),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y)
    );

    term_fb_ctrl #(.BLINK_CYCLES(4)) dut_b (
        .clk_25mhz (clk_25mhz),
        .resetn    (resetn_b),
        .bus       (bif.slave),
        .top_row   (top_row_b),
        .cursor_x  (cursor_x_b),
        .cursor_y  (cursor_y_b)
    );

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0;
    logic [19:0] sb_q[$];
    int m_x, m_y, m_top;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboard monitor for the main DUT
    always @(negedge clk_25mhz) begin
        logic [19:0] e;
        if (fif.fb_we === 1'b1) begin
            wr_cnt++;
            chk("addr_range", 32'(fif.fb_addr < 12'd2400), 32'd1);
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_write", {20'd0, fif.fb_addr}, 32'hFFFFFFFF);
            end else begin
                e = sb_q.pop_front();
                chk("sb_write", {12'd0, fif.fb_addr, fif.fb_wdata}, {12'd0, e});
            end
        end
    end

    task automatic push_clear_all();
        for (int a = 0; a < 2400; a++) sb_q.push_back({12'(a), 8'h20});
    endtask

    task automatic model_byte(input logic [7:0] b, output logic exp_we);
        int  addr;
        int  old;
        logic lf;
        addr   = ((m_top + m_y) % 30) * 80 + m_x;
        lf     = 1'b0;
        exp_we = 1'b1;
        if (b >= 8'h20 && b <= 8'h7E) begin
            sb_q.push_back({12'(addr), b});
            if (m_x == 79) begin m_x = 0; lf = 1'b1; end
            else m_x++;
        end else if (b == 8'h0D) begin
            sb_q.push_back({12'(addr), 8'h20});
            m_x = 0;
        end else if (b == 8'h0A) begin
            sb_q.push_back({12'(addr), 8'h20});
            lf = 1'b1;
        end else if (b == 8'h08) begin
            sb_q.push_back({12'(addr), 8'h20});
            if (m_x > 0) m_x--;
        end else begin
            exp_we = 1'b0;
        end
        if (lf) begin
            if (m_y == 29) begin
                old   = m_top;
                m_top = (m_top + 1) % 30;
                for (int c = 0; c < 80; c++) sb_q.push_back({12'(old * 80 + c), 8'h20});
            end else begin
                m_y++;
            end
        end
    endtask

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        while (fif.in_ready !== 1'b1 && n < budget) begin
            @(negedge clk_25mhz);
            n++;
        end
        chk("ready_timeout", 32'(fif.in_ready), 32'd1);
    endtask

    task automatic check_cursor(input string tag);
        chk({tag, "_x"},   32'(cursor_x), 32'(m_x));
        chk({tag, "_y"},   32'(cursor_y), 32'(m_y));
        chk({tag, "_top"}, 32'(top_row),  32'(m_top));
    endtask

    task automatic send(input logic [7:0] b, input bit wait_done);
        logic exp_we;
        model_byte(b, exp_we);
        wait_ready(300);
        fif.in_valid = 1'b1;
        fif.in_data  = b;
        @(negedge clk_25mhz);
        fif.in_valid = 1'b0;
        chk("we_latency", 32'(fif.fb_we), 32'(exp_we));
        if (wait_done) begin
            @(negedge clk_25mhz);
            wait_ready(300);
            check_cursor("cursor");
        end
    endtask

    task automatic drain_check(input string tag);
        @(negedge clk_25mhz);
        chk(tag, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        int b_we;
        fif.in_valid = 1'b0;
        fif.in_data  = 8'h00;
        bif.in_valid = 1'b0;
        bif.in_data  = 8'h00;
        m_x = 0; m_y = 0; m_top = 0;

        repeat (3) @(negedge clk_25mhz);
        chk("rst_in_ready", 32'(fif.in_ready), 32'd0);
        chk("rst_fb_we",    32'(fif.fb_we),    32'd0);
        chk("rst_fb_addr",  32'(fif.fb_addr),  32'd0);
        chk("rst_fb_wdata", 32'(fif.fb_wdata), 32'd0);
        check_cursor("rst");

        // power-up clear of the whole screen
        push_clear_all();
        wr_cnt = 0;
        resetn = 1'b1;
        wait_ready(3000);
        drain_check("clear_all_drain");
        chk("clear_all_count", 32'(wr_cnt), 32'd2400);

        send(8'h41, 1'b1);
        send(8'h08, 1'b1);
        send(8'h08, 1'b1);
        send(8'h01, 1'b1);
        for (int i = 0; i < 80; i++) send(8'h41, 1'b1);
        send(8'h42, 1'b1);
        send(8'h0D, 1'b1);
        for (int i = 0; i < 5; i++) send(8'h43, 1'b1);
        for (int i = 0; i < 28; i++) send(8'h0A, 1'b1);
        // scroll from the bottom row: write at 2325, then clear row 0
        send(8'h0A, 1'b1);
        drain_check("scroll_drain");
        send(8'h42, 1'b1);
        drain_check("after_scroll_drain");

        // reset in the middle of CLEAR_ROW
        send(8'h0A, 1'b0);
        repeat (10) @(negedge clk_25mhz);
        resetn = 1'b0;
        @(posedge clk_25mhz);
        #1;
        sb_q.delete();
        m_x = 0; m_y = 0; m_top = 0;
        repeat (2) @(negedge clk_25mhz);
        chk("midrst_top", 32'(top_row), 32'd0);
        chk("midrst_we",  32'(fif.fb_we), 32'd0);
        push_clear_all();
        wr_cnt = 0;
        resetn = 1'b1;
        wait_ready(3000);
        drain_check("reclear_drain");
        chk("reclear_count", 32'(wr_cnt), 32'd2400);
        check_cursor("reclear");

        // blink behaviour on the fast-blink instance
        bif.in_valid = 1'b1;
        bif.in_data  = 8'h00;
        resetn_b     = 1'b1;
        n = 0;
        while (bif.in_ready !== 1'b1 && n < 3000) begin
            @(negedge clk_25mhz);
            n++;
        end
        chk("b_ready", 32'(bif.in_ready), 32'd1);
        b_we = 0;
        repeat (10) begin
            @(negedge clk_25mhz);
            b_we += int'(bif.fb_we);
        end
        chk("b_no_blink_while_valid", 32'(b_we), 32'd0);
        bif.in_valid = 1'b0;
        n = 0;
        @(negedge clk_25mhz);
        while (bif.fb_we !== 1'b1 && n < 20) begin
            @(negedge clk_25mhz);
            n++;
        end
        chk("b_blink_we",    32'(bif.fb_we),    32'd1);
        chk("b_blink_addr",  32'(bif.fb_addr),  32'd0);
        chk("b_blink_data",  32'(bif.fb_wdata), 32'h5F);
        chk("b_blink_ready", 32'(bif.in_ready), 32'd0);
        n = 0;
        @(negedge clk_25mhz);
        while (bif.fb_we !== 1'b1 && n < 20) begin
            @(negedge clk_25mhz);
            n++;
        end
        chk("b_blink2_we",   32'(bif.fb_we),    32'd1);
        chk("b_blink2_data", 32'(bif.fb_wdata), 32'h20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
